thresh_frame_ctrl: RTL and testbench

- Frame-level sequencer for the double-threshold (hysteresis-classify) stage of the Canny pipeline.
- Sits between the 3x3 window line-buffer output and the threshold datapath.
- Latches per-frame TH/TL configuration, counts row/column, and drives the datapath start.
- Masks image-border pixels to zero and re-times valid/SOF/EOL/EOF markers to the datapath output; reports frame completion and protocol errors.

---
 rtl/canny_pkg.sv | 25 ++
 rtl/tc_sideband_delay.sv | 40 ++++
 rtl/thresh_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_thresh_frame_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and defaults for the Canny threshold stage: data width, default
// thresholds, frame-sequencer state codes and the per-pixel sideband record.
package canny_pkg;

    localparam int DW = 16;

    localparam logic [15:0] TH_DEF = 16'd22943;
    localparam logic [15:0] TL_DEF = 16'd17208;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic border;
        logic sof;
        logic eol;
        logic eof;
    } sideband_t;

    localparam int SB_W = $bits(sideband_t);

endpackage

// File: rtl/tc_sideband_delay.sv
// LAT-deep shift register carrying a sideband word plus valid bit, used to
// re-align per-pixel markers with a fixed-latency datapath.
module tc_sideband_delay
    import canny_pkg::*;
#(
    parameter int LAT = 2,
    parameter int W   = SB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [W-1:0] sb_i,
    output logic         valid_o,
    output logic [W-1:0] sb_o
);

    logic [LAT-1:0] vld_q;
    logic [W-1:0]   sb_q [LAT];

    // Shifts every cycle regardless of valid so alignment is purely by time.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            sb_q[0]  <= sb_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                sb_q[i]  <= sb_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign sb_o    = sb_q[LAT-1];

endmodule

// File: rtl/thresh_frame_ctrl.sv
// Frame sequencer for the double-threshold stage: latches thresholds per frame,
// tracks row/column, masks borders and re-times frame markers to the output.
module thresh_frame_ctrl #(
    parameter int             IMG_W  = 640,
    parameter int             IMG_H  = 480,
    parameter int             DW     = canny_pkg::DW,
    parameter int             LAT    = 2,
    parameter logic [DW-1:0]  TH_DEF = DW'(canny_pkg::TH_DEF),
    parameter logic [DW-1:0]  TL_DEF = DW'(canny_pkg::TL_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          cfg_use_def,
    input  logic [DW-1:0] cfg_th,
    input  logic [DW-1:0] cfg_tl,
    input  logic          win_valid,
    output logic          dp_start,
    output logic [DW-1:0] dp_th,
    output logic [DW-1:0] dp_tl,
    input  logic [DW-1:0] dp_data,
    input  logic          dp_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          frame_done,
    output logic          busy,
    output logic          cfg_err,
    output logic          seq_err
);
    import canny_pkg::*;

    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DCW = $clog2(LAT + 1);

    localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LAT - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [DW-1:0] th_q, th_d, tl_q, tl_d;
    logic          cfg_err_q, cfg_err_d, seq_err_q, seq_err_d;
    logic          out_valid_q, out_sof_q, out_eol_q, out_eof_q;
    logic [DW-1:0] out_data_q;

    logic [DW-1:0] sel_th, sel_tl;
    sideband_t     sb_in, sb_out;
    logic          sb_vld;

    assign sel_th   = cfg_use_def ? TH_DEF : cfg_th;
    assign sel_tl   = cfg_use_def ? TL_DEF : cfg_tl;
    assign dp_start = (state_q == S_RUN) & win_valid;
    assign busy     = (state_q == S_ARM) | (state_q == S_RUN) | (state_q == S_DRAIN);

    always_comb begin
        sb_in.border = (col_q == '0) | (col_q == COL_LAST) | (row_q == '0) | (row_q == ROW_LAST);
        sb_in.sof    = (col_q == '0) & (row_q == '0);
        sb_in.eol    = (col_q == COL_LAST);
        sb_in.eof    = (col_q == COL_LAST) & (row_q == ROW_LAST);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        drain_d   = drain_q;
        th_d      = th_q;
        tl_d      = tl_q;
        cfg_err_d = cfg_err_q;
        seq_err_d = seq_err_q;

        if (frame_start && busy) begin
            seq_err_d = 1'b1;
        end
        if (win_valid && ((state_q == S_IDLE) || (state_q == S_ARM) || (state_q == S_DRAIN))) begin
            seq_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                // An inverted pair is collapsed onto TH so the datapath never sees TL > TH.
                th_d = sel_th;
                if (sel_tl > sel_th) begin
                    tl_d      = sel_th;
                    cfg_err_d = 1'b1;
                end else begin
                    tl_d = sel_tl;
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (win_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                col_d   = '0;
                row_d   = '0;
                drain_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            drain_q   <= '0;
            th_q      <= TH_DEF;
            tl_q      <= TL_DEF;
            cfg_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            drain_q   <= drain_d;
            th_q      <= th_d;
            tl_q      <= tl_d;
            cfg_err_q <= cfg_err_d;
            seq_err_q <= seq_err_d;
        end
    end

    tc_sideband_delay #(
        .LAT (LAT),
        .W   (SB_W)
    ) u_sb_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (dp_start),
        .sb_i    (sb_in),
        .valid_o (sb_vld),
        .sb_o    (sb_out)
    );

    // Gating with the delay-line valid drops stray dp_ready left over from a reset mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= dp_ready & sb_vld;
            out_data_q  <= sb_out.border ? '0 : dp_data;
            out_sof_q   <= dp_ready & sb_vld & sb_out.sof;
            out_eol_q   <= dp_ready & sb_vld & sb_out.eol;
            out_eof_q   <= dp_ready & sb_vld & sb_out.eof;
        end
    end

    assign dp_th      = th_q;
    assign dp_tl      = tl_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign frame_done = (state_q == S_DONE);
    assign cfg_err    = cfg_err_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_thresh_frame_ctrl.sv
// Self-checking bench for thresh_frame_ctrl on an 8x4 frame with a 2-cycle datapath stub,
// compared every cycle against a timeline-based reference model.
module tb_thresh_frame_ctrl;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;
    localparam logic [15:0] THD = 16'd22943;
    localparam logic [15:0] TLD = 16'd17208;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        cfg_use_def = 1'b1;
    logic [15:0] cfg_th = 16'h0;
    logic [15:0] cfg_tl = 16'h0;
    logic        win_valid = 1'b0;
    logic        dp_start;
    logic [15:0] dp_th, dp_tl, dp_data, out_data;
    logic        dp_ready, out_valid, out_sof, out_eol, out_eof;
    logic        frame_done, busy, cfg_err, seq_err;

    logic        stub0 = 1'b0;
    logic        stub1 = 1'b0;
    logic [15:0] dataVal = 16'h6000;

    thresh_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DW(16), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_use_def(cfg_use_def),
        .cfg_th(cfg_th), .cfg_tl(cfg_tl), .win_valid(win_valid), .dp_start(dp_start),
        .dp_th(dp_th), .dp_tl(dp_tl), .dp_data(dp_data), .dp_ready(dp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_eof(out_eof), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Datapath stub: answers every start exactly LAT=2 cycles later; not reset on purpose.
    always @(posedge clk) begin
        stub0 <= dp_start;
        stub1 <= stub0;
    end
    assign dp_ready = stub1;
    assign dp_data  = dataVal;

    bit          act = 0;
    int          fsE = 0, lastE = 0, pix = 0, edgeN = 0;
    bit          mSeqErr = 0, mCfgErr = 0;
    logic [15:0] mTh = THD, mTl = TLD;
    int          dueQ[$];
    int          kQ[$];
    int          obsOut = 0, obsDone = 0;
    int          nAssert = 0, nFail = 0;

    // Phase sampled at edge n: 0 idle, 1 arm, 2 run, 3 drain, 4 done.
    function automatic int phaseAt(int n);
        if (!act) return 0;
        if (n == fsE + 1) return 1;
        if (pix < NPIX) return 2;
        if (n <= lastE + LAT) return 3;
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edgeN);
        end
    endtask

    task automatic checkOutput();
        int  ph;
        int  k, row, col;
        bit  ev, border;
        ph = phaseAt(edgeN + 1);
        ev = 0;
        k  = 0;
        if (dueQ.size() > 0 && dueQ[0] == edgeN) begin
            ev = 1;
            void'(dueQ.pop_front());
            k = kQ.pop_front();
        end
        chk("out_valid", out_valid, ev);
        if (ev) begin
            row    = k / W;
            col    = k % W;
            border = (row == 0) || (row == H - 1) || (col == 0) || (col == W - 1);
            chk("out_data", out_data, border ? 16'h0 : dataVal);
            chk("out_sof", out_sof, k == 0);
            chk("out_eol", out_eol, col == W - 1);
            chk("out_eof", out_eof, k == NPIX - 1);
        end else begin
            chk("markers_idle", {out_sof, out_eol, out_eof}, 3'b000);
        end
        chk("frame_done", frame_done, ph == 4);
        chk("busy", busy, (ph >= 1) && (ph <= 3));
        chk("cfg_err", cfg_err, mCfgErr);
        chk("seq_err", seq_err, mSeqErr);
        chk("dp_th", dp_th, mTh);
        chk("dp_tl", dp_tl, mTl);
        obsOut  += int'(out_valid);
        obsDone += int'(frame_done);
    endtask

    task automatic applyStimulus(input logic fs, input logic wv);
        int          ph;
        logic [15:0] st, stl;
        frame_start = fs;
        win_valid   = wv;
        #1;
        ph = phaseAt(edgeN + 1);
        if (!rst) chk("dp_start", dp_start, (ph == 2) && wv);
        @(posedge clk);
        edgeN++;
        if (rst) begin
            act = 0; pix = 0; mSeqErr = 0; mCfgErr = 0; mTh = THD; mTl = TLD;
            dueQ.delete();
            kQ.delete();
        end else begin
            if (fs && ph >= 1 && ph <= 3) mSeqErr = 1;
            if (wv && (ph == 0 || ph == 1 || ph == 3)) mSeqErr = 1;
            if (ph == 1) begin
                st  = cfg_use_def ? THD : cfg_th;
                stl = cfg_use_def ? TLD : cfg_tl;
                mTh = st;
                if (stl > st) begin
                    mTl = st;
                    mCfgErr = 1;
                end else begin
                    mTl = stl;
                end
            end
            if (ph == 2 && wv) begin
                dueQ.push_back(edgeN + LAT);
                kQ.push_back(pix);
                if (pix == NPIX - 1) lastE = edgeN;
                pix++;
            end
            if (ph == 4) act = 0;
            if (ph == 0 && fs) begin
                act = 1; fsE = edgeN; pix = 0;
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    // pattern: 0 continuous, 1 alternating, 2 random; fsAt/rstAt/chgAt are pixel indices or -1.
    task automatic runFrame(input int pattern, input int fsAt, input int rstAt,
                            input int chgAt, input bit fsOnDone);
        int   bound, tg, ph;
        bit   fsDone;
        logic wv, fs;
        bound = 0; tg = 0; fsDone = 0;
        obsOut = 0; obsDone = 0;
        applyStimulus(1'b1, 1'b0);
        while (act && bound < 500) begin
            ph = phaseAt(edgeN + 1);
            if (rstAt >= 0 && pix == rstAt && ph == 2) begin
                doReset();
                idle(4);
                chk("no_done_on_reset", obsDone, 0);
                return;
            end
            wv = 1'b0;
            if (ph == 2) begin
                case (pattern)
                    0: wv = 1'b1;
                    1: begin wv = (tg % 2 == 0); tg++; end
                    default: wv = ($urandom_range(0, 3) != 0);
                endcase
            end
            fs = 1'b0;
            if (fsAt >= 0 && pix == fsAt && !fsDone && ph == 2) begin
                fs = 1'b1;
                fsDone = 1;
            end
            if (fsOnDone && ph == 4) fs = 1'b1;
            if (chgAt >= 0 && pix == chgAt && ph == 2) cfg_th = cfg_th + 16'h0101;
            applyStimulus(fs, wv);
            bound++;
        end
        chk("frame_timeout", bound < 500, 1'b1);
        chk("frame_out_count", obsOut, NPIX);
        chk("frame_done_count", obsDone, 1);
    endtask

    initial begin
        #2;
        doReset();
        idle(2);

        $display("[TB] continuous frame, default thresholds");
        runFrame(0, -1, -1, -1, 1'b0);
        idle(3);

        $display("[TB] alternating win_valid, frame_start on DONE");
        runFrame(1, -1, -1, -1, 1'b1);
        idle(3);

        $display("[TB] inverted programmed thresholds, mid-frame cfg change");
        cfg_use_def = 1'b0;
        cfg_th = 16'h4000;
        cfg_tl = 16'h5000;
        runFrame(0, -1, -1, 5, 1'b0);
        idle(2);

        $display("[TB] frame_start while running");
        doReset();
        cfg_use_def = 1'b1;
        runFrame(0, 10, -1, -1, 1'b0);
        idle(2);
        runFrame(0, -1, -1, -1, 1'b0);
        idle(2);

        $display("[TB] reset mid-frame then full frame");
        runFrame(0, -1, 17, -1, 1'b0);
        runFrame(0, -1, -1, -1, 1'b0);
        idle(2);

        $display("[TB] win_valid pulse in IDLE");
        doReset();
        applyStimulus(1'b0, 1'b1);
        idle(4);

        $display("[TB] randomized frames");
        for (int f = 0; f < 4; f++) begin
            cfg_use_def = 1'($urandom_range(0, 1));
            cfg_th      = 16'($urandom);
            cfg_tl      = 16'($urandom);
            dataVal     = 16'($urandom);
            runFrame(2, -1, -1, -1, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
